// File: rtl/load_store_unit.sv
// RV32I load/store unit between execute and a word-ported data memory.
// Sub-word stores use read-modify-write; faulting requests never touch memory.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_FAULT  = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  state_e      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        fault_q;
  logic        mem_write_q;
  logic        mem_read_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_lo_q;

  logic        accept_d;
  logic [32:0] acc_size_d;
  logic        legal_d;
  logic        misalign_d;
  logic        range_d;
  logic        req_fault_d;

  // Pick the addressed byte/half out of the word and extend it per funct3.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    if (lane[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Overlay the new byte/half onto the word read back from memory.
  function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] old_word,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = old_word;
    case (f3)
      3'b000: begin
        case (lane)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          2'b11:   r[31:24] = wd[7:0];
          default: r        = old_word;
        endcase
      end
      3'b001: begin
        if (lane[1]) begin
          r[31:16] = wd;
        end else begin
          r[15:0] = wd;
        end
      end
      default: r = old_word;
    endcase
    return r;
  endfunction

  // Request decode: legality, alignment and range are judged on the live inputs.
  always_comb begin
    accept_d = req_valid && req_ready_q;
    case (funct3[1:0])
      2'b00:   acc_size_d = 33'd1;
      2'b01:   acc_size_d = 33'd2;
      default: acc_size_d = 33'd4;
    endcase
    case (funct3[1:0])
      2'b01:   misalign_d = addr[0];
      2'b10:   misalign_d = (addr[1:0] != 2'b00);
      default: misalign_d = 1'b0;
    endcase
    if (req_write) begin
      legal_d = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal_d = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    range_d     = (({1'b0, addr} + acc_size_d) > 33'(MEM_BYTES));
    req_fault_d = !legal_d || misalign_d || range_d;
  end

  // Sequencer with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      fault_q          <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      rdata_q          <= 32'h0000_0000;
      mem_address_q    <= 32'h0000_0000;
      mem_write_data_q <= 32'h0000_0000;
      funct3_q         <= 3'b000;
      lane_q           <= 2'b00;
      wdata_lo_q       <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          fault_q      <= 1'b0;
          if (accept_d) begin
            funct3_q      <= funct3;
            lane_q        <= addr[1:0];
            wdata_lo_q    <= wdata[15:0];
            mem_address_q <= {addr[31:2], 2'b00};
            req_ready_q   <= 1'b0;
            if (req_fault_d) begin
              state_q      <= S_FAULT;
              resp_valid_q <= 1'b1;
              fault_q      <= 1'b1;
              rdata_q      <= 32'h0000_0000;
            end else if (!req_write) begin
              state_q    <= S_LOAD;
              mem_read_q <= 1'b1;
            end else if (funct3 == 3'b010) begin
              state_q          <= S_WRITE;
              mem_write_q      <= 1'b1;
              mem_write_data_q <= wdata;
            end else begin
              state_q    <= S_RMW_RD;
              mem_read_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          mem_read_q   <= 1'b0;
          rdata_q      <= extend_load(funct3_q, lane_q, mem_read_data);
          resp_valid_q <= 1'b1;
          fault_q      <= 1'b0;
          state_q      <= S_RESP;
        end
        S_RMW_RD: begin
          mem_read_q       <= 1'b0;
          mem_write_q      <= 1'b1;
          mem_write_data_q <= merge_store(funct3_q, lane_q, mem_read_data, wdata_lo_q);
          state_q          <= S_WRITE;
        end
        S_WRITE: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          fault_q      <= 1'b0;
          rdata_q      <= 32'h0000_0000;
          state_q      <= S_RESP;
        end
        S_FAULT: begin
          resp_valid_q <= 1'b0;
          fault_q      <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          rdata_q      <= 32'h0000_0000;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          fault_q      <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_read_q   <= 1'b0;
          rdata_q      <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign fault          = fault_q;
  assign rdata          = rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, word-array memory.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int MEMB = 128;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wword;
    int          lat;
    int          acc;
    int          nrd;
    int          nwr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic [31:0] dmem    [0:31];
  logic [7:0]  ref_mem [0:MEMB-1];
  logic [7:0]  ref_bak [0:MEMB-1];
  exp_t        sb[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          resp_total = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  load_store_unit #(.MEM_BYTES(MEMB)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .fault(fault),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = (mem_address < 32'd128) ? dmem[mem_address[6:2]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: preload, then accept write strobes.
  initial begin
    for (int i = 0; i < 32; i++) dmem[i] = $urandom;
    dmem[4] = 32'h8081_7F01;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 4; j++) ref_mem[7'(4*i+j)] = dmem[i][8*j +: 8];
    forever begin
      @(posedge clock);
      if (mem_write && mem_address < 32'd128) dmem[mem_address[6:2]] = mem_write_data;
    end
  end

  // Reference model: byte-level memory semantics.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int size;
    bit legal;
    bit signed_ld;
    longint unsigned val;
    longint unsigned ea;
    size  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    legal = w ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    ea    = {32'h0, a} + 64'(size);
    e.addr = {a[31:2], 2'b00};
    e.rdata = 32'h0; e.wword = 32'h0; e.fault = 1'b0; e.acc = 0;
    if (!legal || (a % size) != 0 || ea > 64'(MEMB)) begin
      e.fault = 1'b1; e.lat = 1; e.nrd = 0; e.nwr = 0;
    end else if (!w) begin
      val = 64'd0;
      for (int i = 0; i < size; i++) val = val | (64'(ref_mem[7'(int'(a) + i)]) << (8*i));
      signed_ld = (f3 == 3'd0) || (f3 == 3'd1);
      if (signed_ld && val[8*size-1]) val = val - (64'd1 << (8*size));
      e.rdata = val[31:0];
      e.lat = 2; e.nrd = 1; e.nwr = 0;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[7'(int'(a) + i)] = wd[8*i +: 8];
      for (int j = 0; j < 4; j++) e.wword[8*j +: 8] = ref_mem[7'(int'(e.addr) + j)];
      e.lat = (size == 4) ? 2 : 3;
      e.nrd = (size == 4) ? 0 : 1;
      e.nwr = 1;
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_c, input logic [31:0] c,
                       output int acc);
    exp_t e;
    int   n;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = wd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready still 0 after 40 cycles, required 1");
      req_valid = 1'b0;
      acc = -1;
    end else begin
      model(w, f3, a, wd, e);
      if (use_c) e.rdata = c;
      acc = cyc + 1;
      e.acc = acc;
      sb.push_back(e);
      @(posedge clock);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: strobe checks each cycle, response checks against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        sb.delete();
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (mem_read || mem_write) begin
          chk("strobe_excl", 32'(mem_read && mem_write), 32'h0);
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL stray_strobe: rd=%0b wr=%0b with nothing outstanding", mem_read, mem_write);
          end else begin
            chk("mem_address", mem_address, sb[0].addr);
            if (mem_write) chk("mem_write_data", mem_write_data, sb[0].wword);
          end
          if (mem_read) rd_cnt++;
          if (mem_write) wr_cnt++;
        end
        if (resp_valid) begin
          resp_total++;
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding");
          end else begin
            e = sb.pop_front();
            chk("fault", 32'(fault), 32'(e.fault));
            chk("rdata", rdata, e.rdata);
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("read_strobes", 32'(rd_cnt), 32'(e.nrd));
            chk("write_strobes", 32'(wr_cnt), 32'(e.nwr));
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    int a0, a1, a2, acc, snap;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    reset = 1'b1;

    issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b1, 32'h0000_007F, acc);
    issue(1'b0, 3'b000, 32'h12, 32'h0, 1'b1, 32'hFFFF_FF81, acc);
    issue(1'b0, 3'b100, 32'h12, 32'h0, 1'b1, 32'h0000_0081, acc);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFF_8081, acc);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 32'h0000_7F01, acc);
    issue(1'b1, 3'b000, 32'h13, 32'h1234_56AA, 1'b1, 32'h0, acc);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hAA81_7F01, acc);
    issue(1'b1, 3'b001, 32'h10, 32'h0000_BEEF, 1'b1, 32'h0, acc);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hAA81_BEEF, acc);
    issue(1'b1, 3'b010, 32'h7C, 32'hDEAD_BEEF, 1'b1, 32'h0, acc);
    issue(1'b0, 3'b010, 32'h7C, 32'h0, 1'b1, 32'hDEAD_BEEF, acc);
    issue(1'b0, 3'b010, 32'h80, 32'h0, 1'b1, 32'h0, acc);
    issue(1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h0, acc);
    issue(1'b1, 3'b010, 32'h06, 32'h5555_AAAA, 1'b1, 32'h0, acc);
    issue(1'b0, 3'b011, 32'h20, 32'h0, 1'b1, 32'h0, acc);

    // Back-to-back loads with req_valid held high.
    issue(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 32'h0, a0);
    issue(1'b0, 3'b000, 32'h05, 32'h0, 1'b0, 32'h0, a1);
    issue(1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, 32'h0, a2);
    chk("b2b_gap1", 32'(a1 - a0), 32'd3);
    chk("b2b_gap2", 32'(a2 - a1), 32'd3);

    for (int k = 0; k < 200; k++) begin
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 135);
      issue(w, f3, a, $urandom, 1'b0, 32'h0, acc);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 3)));
    end
    idle(0);
    drain();

    // Reset while an SB is in its write cycle.
    for (int i = 0; i < MEMB; i++) ref_bak[i] = ref_mem[i];
    issue(1'b1, 3'b000, 32'h21, 32'h0000_0033, 1'b0, 32'h0, acc);
    @(posedge clock);
    #2;
    chk("rst_mid_wr_before", 32'(mem_write), 32'h1);
    snap = resp_total;
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_mid_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mid_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'h1);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_mid_mem_address", mem_address, 32'h0);
    chk("rst_mid_mem_wdata", mem_write_data, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("no_resp_after_rst", 32'(resp_total), 32'(snap));
    chk("ready_after_rst", 32'(req_ready), 32'h1);
    for (int i = 0; i < MEMB; i++) ref_mem[i] = ref_bak[i];
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0, acc);
    idle(0);
    drain();
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
